// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: size codes, response owner, word width.
package mem_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection between fetch (I) and load/store (D) requesters.
// Default: fixed D priority with a starvation guard that forces I after
// MAX_WAIT consecutive D grants while I waits.
// MEM_ARB_RR_EN: round-robin, the last grantee loses a tie.
module mem_arb_grant #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_valid,
    input  logic d_valid,
    output logic i_grant_c,
    output logic d_grant_c
);

`ifdef MEM_ARB_RR_EN
    logic last_i_q;
    logic last_i_d;

    // Round-robin grant and last-grantee tracking
    always_comb begin
        i_grant_c = 1'b0;
        d_grant_c = 1'b0;
        last_i_d  = last_i_q;
        if (!RST) begin
            if (i_valid && d_valid) begin
                if (last_i_q) d_grant_c = 1'b1;
                else          i_grant_c = 1'b1;
            end else begin
                i_grant_c = i_valid;
                d_grant_c = d_valid;
            end
        end
        if (i_grant_c)      last_i_d = 1'b1;
        else if (d_grant_c) last_i_d = 1'b0;
    end

    // Last-grantee register
    always_ff @(posedge CLK) begin
        if (RST) last_i_q <= 1'b0;
        else     last_i_q <= last_i_d;
    end
`else
    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    logic          starve;

    // Fixed D priority, I forced once the wait budget is spent
    always_comb begin
        starve    = (wait_cnt_q == CW'(MAX_WAIT));
        d_grant_c = ~RST & d_valid & ~(i_valid & starve);
        i_grant_c = ~RST & i_valid & ~d_grant_c;
        wait_cnt_d = wait_cnt_q;
        if (!i_valid || i_grant_c) wait_cnt_d = '0;
        else if (d_grant_c && !starve) wait_cnt_d = wait_cnt_q + CW'(1);
    end

    // Starvation counter register
    always_ff @(posedge CLK) begin
        if (RST) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between instruction fetch (I) and
// load/store (D). Issue is combinational on the grant cycle; the response is
// routed back to its owner exactly one cycle later.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned SIZE     = 5,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [SIZE+2:0]     i_req_addr,
    input  logic                i_flush,
    output logic                i_rsp_valid,
    output logic [WORD_W-1:0]   i_rsp_data,
    output logic                i_rsp_err,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [SIZE+2:0]     d_req_addr,
    input  logic [2:0]          d_req_size,
    input  logic [WORD_W-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    output logic [WORD_W-1:0]   d_rsp_data,
    output logic                d_rsp_err,
    output logic                mem_en,
    output logic                mem_wr_rd,
    output logic [SIZE+2:0]     mem_addr,
    output logic [2:0]          mem_size,
    output logic [WORD_W-1:0]   mem_wdata,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                mem_exception
);

    localparam int unsigned AW = SIZE + 3;

    logic              i_gnt;
    logic              d_gnt;
    logic [AW-1:0]     addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    owner_e            owner_q, owner_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic              flush_q, flush_d;
    logic              i_live;
    logic              d_live;
    logic              rd_ok;

    mem_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .CLK       (CLK),
        .RST       (RST),
        .i_valid   (i_req_valid),
        .d_valid   (d_req_valid),
        .i_grant_c (i_gnt),
        .d_grant_c (d_gnt)
    );

    // Issue mux: winner drives the memory, otherwise address/size/data hold
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        if (d_gnt) begin
            addr_d  = d_req_addr;
            size_d  = d_req_size;
            wdata_d = d_req_wdata;
        end else if (i_gnt) begin
            addr_d = i_req_addr;
            size_d = SZ_W;
        end
        i_req_ready = i_gnt;
        d_req_ready = d_gnt;
        mem_en      = i_gnt | d_gnt;
        mem_wr_rd   = d_gnt & d_req_we & ~mem_exception;
        mem_addr    = RST ? '0 : addr_d;
        mem_size    = RST ? '0 : size_d;
        mem_wdata   = RST ? '0 : wdata_d;
    end

    // Response tag captured on the issue cycle
    always_comb begin
        owner_d = OWN_NONE;
        if (d_gnt)      owner_d = OWN_D;
        else if (i_gnt) owner_d = OWN_I;
        err_d   = (i_gnt | d_gnt) & mem_exception;
        we_d    = d_gnt & d_req_we;
        flush_d = i_gnt & i_flush;
    end

    // Held issue fields and response pipeline registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            we_q    <= we_d;
            flush_q <= flush_d;
        end
    end

    // Response routing; a late flush or reset kills the returning response
    always_comb begin
        i_live      = ~RST & (owner_q == OWN_I) & ~flush_q & ~i_flush;
        d_live      = ~RST & (owner_q == OWN_D);
        rd_ok       = ~we_q & ~err_q;
        i_rsp_valid = i_live;
        i_rsp_err   = i_live & err_q;
        i_rsp_data  = (i_live & rd_ok) ? mem_rdata : '0;
        d_rsp_valid = d_live;
        d_rsp_err   = d_live & err_q;
        d_rsp_data  = (d_live & rd_ok) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory plus a reference model of
// grant order, issue signals and tagged one-cycle responses.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int unsigned SIZE     = 5;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned AW       = SIZE + 3;

    logic          CLK, RST;
    logic          i_req_valid, i_req_ready, i_flush, i_rsp_valid, i_rsp_err;
    logic [AW-1:0] i_req_addr;
    logic [31:0]   i_rsp_data;
    logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
    logic [AW-1:0] d_req_addr;
    logic [2:0]    d_req_size;
    logic [31:0]   d_req_wdata, d_rsp_data;
    logic          mem_en, mem_wr_rd, mem_exception;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_size;
    logic [31:0]   mem_wdata, mem_rdata;

    mem_port_arbiter #(.SIZE(SIZE), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_flush(i_flush), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_en(mem_en), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_exception(mem_exception)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents seen by the DUT, and the model's own copy
    logic [7:0] tb_mem  [256];
    logic [7:0] ref_mem [256];

    int checks   = 0;
    int failures = 0;

    // Model state
    int          mw = 0;
    int          p_own = 0;
    logic [31:0] p_data = '0;
    logic        p_err = 1'b0;
    logic        p_flush = 1'b0;
    logic [7:0]  ea_hold = '0;
    logic [2:0]  es_hold = '0;
    logic [31:0] wd_hold = '0;
    logic        g_i_last = 1'b0;
    logic        g_d_last = 1'b0;
    logic        obs_i_ready;

    function automatic logic misal(input logic [7:0] a, input logic [2:0] sz);
        case (sz)
            SZ_B, SZ_BU: misal = 1'b0;
            SZ_H, SZ_HU: misal = a[0];
            SZ_W:        misal = (a[1:0] != 2'b00);
            default:     misal = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] sz);
        case (sz)
            SZ_B:    ext = {{24{raw[7]}}, raw[7:0]};
            SZ_BU:   ext = {24'h0, raw[7:0]};
            SZ_H:    ext = {{16{raw[15]}}, raw[15:0]};
            SZ_HU:   ext = {16'h0, raw[15:0]};
            SZ_W:    ext = raw;
            default: ext = '0;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        case (sz[1:0])
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            default: nbytes = 4;
        endcase
    endfunction

    // Behavioural single-port memory: registered read, write on the edge
    assign mem_exception = mem_en && misal(mem_addr, mem_size);
    initial mem_rdata = '0;
    always @(posedge CLK) begin
        if (mem_en && !mem_exception) begin
            if (mem_wr_rd) begin
                for (int k = 0; k < nbytes(mem_size); k++)
                    tb_mem[8'(mem_addr + 8'(k))] = mem_wdata[8*k +: 8];
            end else begin
                mem_rdata <= ext({tb_mem[8'(mem_addr + 8'd3)], tb_mem[8'(mem_addr + 8'd2)],
                                  tb_mem[8'(mem_addr + 8'd1)], tb_mem[mem_addr]}, mem_size);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        i_flush     = 1'b0;
        d_req_we    = 1'b0;
    endtask

    // One clock cycle: inputs already driven after a negedge; check, predict, advance
    task automatic step();
        logic       gi, gd, mis, e_iv, e_dv;
        logic [7:0] ea;
        logic [2:0] es;
        logic [31:0] raw;
        #1;
        if (RST) begin
            gi = 1'b0; gd = 1'b0;
        end else begin
            gd = d_req_valid && !(i_req_valid && mw == int'(MAX_WAIT));
            gi = i_req_valid && !gd;
        end
        ea  = gd ? d_req_addr : i_req_addr;
        es  = gd ? d_req_size : SZ_W;
        mis = (gi || gd) && misal(ea, es);
        obs_i_ready = i_req_ready;

        chk("i_req_ready", 32'(i_req_ready), 32'(gi));
        chk("d_req_ready", 32'(d_req_ready), 32'(gd));
        chk("mem_en",      32'(mem_en),      32'(gi || gd));
        chk("mem_wr_rd",   32'(mem_wr_rd),   32'(gd && d_req_we && !mis));
        chk("mem_addr",    32'(mem_addr),  RST ? 32'd0 : 32'((gi || gd) ? ea : ea_hold));
        chk("mem_size",    32'(mem_size),  RST ? 32'd0 : 32'((gi || gd) ? es : es_hold));
        chk("mem_wdata",   mem_wdata,      RST ? 32'd0 : (gd ? d_req_wdata : wd_hold));

        e_iv = !RST && p_own == 1 && !p_flush && !i_flush;
        e_dv = !RST && p_own == 2;
        chk("i_rsp_valid", 32'(i_rsp_valid), 32'(e_iv));
        chk("d_rsp_valid", 32'(d_rsp_valid), 32'(e_dv));
        if (e_iv) begin
            chk("i_rsp_data", i_rsp_data, p_data);
            chk("i_rsp_err",  32'(i_rsp_err), 32'(p_err));
        end
        if (e_dv) begin
            chk("d_rsp_data", d_rsp_data, p_data);
            chk("d_rsp_err",  32'(d_rsp_err), 32'(p_err));
        end
        if (RST) begin
            chk("rst_i_rsp_data", i_rsp_data, 32'd0);
            chk("rst_d_rsp_data", d_rsp_data, 32'd0);
            chk("rst_rsp_err",    32'({i_rsp_err, d_rsp_err}), 32'd0);
        end

        if (RST) begin
            p_own = 0; ea_hold = '0; es_hold = '0; wd_hold = '0; mw = 0;
        end else begin
            if (gi || gd) begin
                raw = {ref_mem[8'(ea + 8'd3)], ref_mem[8'(ea + 8'd2)],
                       ref_mem[8'(ea + 8'd1)], ref_mem[ea]};
                p_own   = gi ? 1 : 2;
                p_err   = mis;
                p_flush = gi && i_flush;
                p_data  = (mis || (gd && d_req_we)) ? 32'd0 : ext(raw, es);
                if (gd && d_req_we && !mis)
                    for (int k = 0; k < nbytes(es); k++)
                        ref_mem[8'(ea + 8'(k))] = d_req_wdata[8*k +: 8];
                ea_hold = ea; es_hold = es;
            end else begin
                p_own = 0;
            end
            if (gd) wd_hold = d_req_wdata;
            if (!i_req_valid || gi)           mw = 0;
            else if (gd && mw < int'(MAX_WAIT)) mw++;
        end
        g_i_last = gi;
        g_d_last = gd;
        @(negedge CLK);
    endtask

    logic [11:0] gseq;
    logic [2:0]  sizes [6];

    initial begin
        sizes[0] = SZ_B; sizes[1] = SZ_H; sizes[2] = SZ_W;
        sizes[3] = SZ_BU; sizes[4] = SZ_HU; sizes[5] = 3'b011;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        {tb_mem[11], tb_mem[10], tb_mem[9], tb_mem[8]}     = 32'hDEADBEEF;
        {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]} = 32'hDEADBEEF;

        idle();
        i_req_addr = '0; d_req_addr = '0; d_req_size = SZ_W; d_req_wdata = '0;
        RST = 1'b1;
        @(negedge CLK);
        step();
        i_req_valid = 1'b1; d_req_valid = 1'b1;     // requests ignored in reset
        step();
        idle(); RST = 1'b0;
        step();

        // Single fetch of 0xDEADBEEF
        i_req_valid = 1'b1; i_req_addr = 8'h08;
        step();
        idle();
        step();

        // Both requesters continuously valid: D x MAX_WAIT then I
        i_req_valid = 1'b1; i_req_addr = 8'h20;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_size = SZ_W; d_req_addr = 8'h40;
        gseq = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            gseq = {gseq[10:0], obs_i_ready};
            if (g_d_last) d_req_addr = {2'($urandom_range(0, 3)) + 2'd1, 4'($urandom), 2'b00};
            if (g_i_last) i_req_addr = {6'($urandom), 2'b00};
        end
        chk("grant_sequence", 32'(gseq), 32'(12'b000010000100));
        idle();
        step();

        // Store word then load it back the next cycle
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = SZ_W;
        d_req_addr = 8'h10; d_req_wdata = 32'h12345678;
        step();
        d_req_we = 1'b0;
        step();
        idle();
        step();
        chk("raw_word_0x10", {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}, 32'h12345678);

        // Misaligned half store must not write; word read afterwards
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_size = SZ_H;
        d_req_addr = 8'h03; d_req_wdata = 32'hFFFF_A5A5;
        step();
        d_req_we = 1'b0; d_req_size = SZ_W; d_req_addr = 8'h00;
        step();
        idle();
        step();

        // Flush on the response cycle, then a normal fetch
        i_req_valid = 1'b1; i_req_addr = 8'h08;
        step();
        idle(); i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_req_valid = 1'b1; i_req_addr = 8'h10;
        step();
        idle();
        step();

        // Flush on the issue cycle
        i_req_valid = 1'b1; i_req_addr = 8'h08; i_flush = 1'b1;
        step();
        idle();
        step();

        // Reset right after a D load issue
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_size = SZ_W; d_req_addr = 8'h08;
        step();
        idle(); RST = 1'b1;
        step();
        RST = 1'b0;
        step();

        // Randomised traffic with hold-while-waiting requesters
        for (int c = 0; c < 400; c++) begin
            if (!(i_req_valid && !g_i_last)) begin
                i_req_valid = ($urandom_range(0, 2) != 0);
                i_req_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {6'($urandom), 2'b00};
            end
            if (!(d_req_valid && !g_d_last)) begin
                d_req_valid = ($urandom_range(0, 2) != 0);
                d_req_we    = 1'($urandom);
                d_req_size  = sizes[$urandom_range(0, 5)];
                d_req_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : {6'($urandom), 2'b00};
                d_req_wdata = $urandom;
            end
            i_flush = ($urandom_range(0, 3) == 0);
            RST     = ($urandom_range(0, 49) == 0);
            step();
        end
        idle(); RST = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data memory (1-cycle registered read, write on clock edge, combinational misalignment exception) between two requesters: the instruction-fetch port (I) and the load/store port (D).
- Sits between the CPU core and the memory.
- Grants at most one request per cycle, drives the memory control signals, and routes the response back one cycle later, tagged to the owner.
- Starvation of I is bounded by a wait counter.

Parameters:
- SIZE, 5, memory depth exponent; byte address width is SIZE+3.
- MAX_WAIT, 4, consecutive D grants allowed while I is pending before I is forced.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- i_req_valid  in  1  fetch request
- i_req_ready  out  1  fetch accepted this cycle
- i_req_addr  in  SIZE+3  fetch byte address; size fixed to word
- i_flush  in  1  discard an outstanding fetch response
- i_rsp_valid  out  1  fetch response
- i_rsp_data  out  32  fetched word
- i_rsp_err  out  1  fetch misaligned
- d_req_valid  in  1  load/store request
- d_req_ready  out  1  load/store accepted
- d_req_we  in  1  1 = store
- d_req_addr  in  SIZE+3  byte address
- d_req_size  in  3  memory size code (000 b, 001 h, 010 w, 100 bu, 101 hu)
- d_req_wdata  in  32  store data
- d_rsp_valid  out  1  load/store response
- d_rsp_data  out  32  load data; 0 for stores
- d_rsp_err  out  1  misaligned/illegal size
- mem_en  out  1  memory enable
- mem_wr_rd  out  1  memory write strobe
- mem_addr  out  SIZE+3  memory address
- mem_size  out  3  memory size code
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (valid the cycle after issue)
- mem_exception  in  1  memory exception (combinational on the issue cycle)

Behaviour:
- Reset: all *_ready, *_rsp_valid, *_rsp_err, mem_en and mem_wr_rd = 0; data outputs = 0; wait_cnt = 0; owner = NONE.
- Grant, combinational per cycle:
  - D wins if d_req_valid and not (i_req_valid and wait_cnt == MAX_WAIT).
  - Otherwise I wins if i_req_valid.
  - Exactly one ready is asserted, and only for the winner.
- Issue cycle (winner's valid & ready):
  - mem_en = 1; mem_addr and mem_size come from the winner; I uses size 010.
  - mem_wr_rd = d_req_we & D-grant & ~mem_exception. A misaligned store never writes.
  - With no winner: mem_en = 0 and mem_wr_rd = 0; mem_addr and mem_size hold their last values.
- Response pipeline (registered): owner (NONE/I/D), err = mem_exception, we.
  - The cycle after issue, the owner's rsp_valid pulses for 1 cycle.
  - rsp_data = mem_rdata for a read without error; otherwise 0.
  - rsp_err = the registered exception.
  - Latency is exactly 1 cycle. Throughput is 1 request per cycle, back-to-back, with no bubbles.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each D grant while i_req_valid.
  - Clears on any I grant or when i_req_valid = 0.
- Flush:
  - i_flush in the cycle an I response is due suppresses i_rsp_valid.
  - i_flush on the issue cycle also suppresses the response the next cycle; the flag is registered.
  - Flush never affects D.
- Simultaneous events:
  - Store issued while an I read response is returning: the I response still shows the pre-write word of its own address.
  - Read-after-write to the same address in consecutive cycles returns the new data.
- Reset mid-operation: any pending response is dropped; no rsp_valid the cycle after RST.
- Requesters must hold addr/data stable while valid & ~ready.

Optional Feature:
- MEM_ARB_RR_EN defined: fixed priority is replaced by round-robin. The last grantee loses a tie. wait_cnt and MAX_WAIT are unused and may be optimised out.
- MEM_ARB_RR_EN undefined: fixed D priority with the MAX_WAIT starvation guard, as above.

Decomposition:
- Shared package mem_pkg holds:
  - size codes: SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b010, SZ_BU=3'b100, SZ_HU=3'b101
  - owner enum: OWN_NONE, OWN_I, OWN_D
  - word width constant 32
- One natural sub-module, mem_arb_grant: combinational winner selection, fixed-priority/starvation or RR (by macro), plus the wait_cnt/last-grant register. The top level keeps issue muxing and the response pipeline.

Test Plan:
- Only I valid, addr 0x08, mem word 0xDEADBEEF → i_req_ready same cycle; i_rsp_valid=1, i_rsp_data=0xDEADBEEF next cycle; d_rsp_valid=0.
- I and D both valid continuously, MAX_WAIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I…; each response appears 1 cycle after its grant on the correct port.
- D store word 0x12345678 @0x10, then D load word @0x10 next cycle → d_rsp_data=0x00000000 for the store and 0x12345678 for the load.
- D store half @0x03 → mem_wr_rd=0, d_rsp_err=1 next cycle, memory unchanged (verified by a later word read).
- I grant with i_flush asserted the following cycle → no i_rsp_valid; a subsequent fetch responds normally.
- RST asserted on the cycle after a D load issue → d_rsp_valid stays 0; all outputs return to reset values.
